// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone parallel-prefix adder/subtractor with a valid/ready
// handshake. The carry-in is folded into bit 0 before the first prefix level.
// A register follows every PIPE_EVERY prefix levels and also the last level.
// The whole pipeline stalls together when the output is held off.
module pipelined_prefix_adder #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 1,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 128 || (1 << LOG2W) != WIDTH) begin : g_bad_width
        $error("pipelined_prefix_adder: WIDTH must be a power of two in 2..128");
    end
    if (PIPE_EVERY < 1 || PIPE_EVERY > LOG2W) begin : g_bad_pipe
        $error("pipelined_prefix_adder: PIPE_EVERY must be in 1..log2(WIDTH)");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("pipelined_prefix_adder: TAG_W must be at least 1");
    end

    // Sideband that rides unchanged through every prefix stage
    typedef struct packed {
        logic [WIDTH-1:0] p;      // stage-0 bitwise propagate, needed for the sum
        logic             am;     // sign bit of a
        logic             bm;     // sign bit of the effective b
        logic             c0;     // effective carry-in
        logic [TAG_W-1:0] tag;
    } side_t;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;

    logic             vld_p0;
    logic [WIDTH-1:0] g_p0;
    side_t            side_p0;

    // Operand conditioning: subtract is a + ~b + 1
    always_comb begin
        b_eff = sub ? ~b : b;
        c0_in = sub ? 1'b1 : cin;
    end

    // ---- stage 0: bitwise generate/propagate and sideband capture ----
    // Stage-0 register, advances whenever the pipeline is not stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            g_p0    <= '0;
            side_p0 <= '0;
        end else if (!stall) begin
            vld_p0      <= in_valid;
            g_p0        <= a & b_eff;
            side_p0.p   <= a ^ b_eff;
            side_p0.am  <= a[WIDTH-1];
            side_p0.bm  <= b_eff[WIDTH-1];
            side_p0.c0  <= c0_in;
            side_p0.tag <= in_tag;
        end
    end

    // Level 0 is the folded stage-0 state; level k is the output of prefix level k
    for (genvar k = 0; k <= LOG2W; k++) begin : g_level
        logic [WIDTH-1:0] g_o;
        logic [WIDTH-1:0] p_o;
        side_t            side_o;
        logic             vld_o;

        if (k == 0) begin : g_src
            // Carry-in acts as generate bit -1 with propagate 0; merging it
            // into bit 0 here makes every group reaching bit 0 include it.
            assign g_o    = {g_p0[WIDTH-1:1], g_p0[0] | (side_p0.p[0] & side_p0.c0)};
            assign p_o    = {side_p0.p[WIDTH-1:1], 1'b0};
            assign side_o = side_p0;
            assign vld_o  = vld_p0;
        end else begin : g_stage
            localparam int D = 1 << (k - 1);
            logic [WIDTH-1:0] g_n;
            logic [WIDTH-1:0] p_n;

            // Prefix combine at span D; low bits already span down to bit -1
            always_comb begin
                g_n = g_level[k-1].g_o;
                p_n = g_level[k-1].p_o;
                for (int i = D; i < WIDTH; i++) begin
                    g_n[i] = g_level[k-1].g_o[i] | (g_level[k-1].p_o[i] & g_level[k-1].g_o[i-D]);
                    p_n[i] = g_level[k-1].p_o[i] & g_level[k-1].p_o[i-D];
                end
            end

            if ((k % PIPE_EVERY == 0) || (k == LOG2W)) begin : g_reg
                // ---- pipeline register after prefix level k ----
                // Stage register, holds on stall, clears on reset
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_o  <= 1'b0;
                        g_o    <= '0;
                        p_o    <= '0;
                        side_o <= '0;
                    end else if (!stall) begin
                        vld_o  <= g_level[k-1].vld_o;
                        g_o    <= g_n;
                        p_o    <= p_n;
                        side_o <= g_level[k-1].side_o;
                    end
                end
            end else begin : g_comb
                assign vld_o  = g_level[k-1].vld_o;
                assign g_o    = g_n;
                assign p_o    = p_n;
                assign side_o = g_level[k-1].side_o;
            end
        end
    end

    // ---- output: sum XOR from the final register stage ----
    logic [WIDTH-1:0] g_f;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_raw;
    side_t            side_f;
    logic             vld_f;
    logic             unused_p;

    assign g_f      = g_level[LOG2W].g_o;
    assign side_f   = g_level[LOG2W].side_o;
    assign vld_f    = g_level[LOG2W].vld_o;
    // The full-width group propagate is not needed once all carries are known
    assign unused_p = ^g_level[LOG2W].p_o;

    assign carry   = {g_f[WIDTH-2:0], side_f.c0};
    assign sum_raw = side_f.p ^ carry;

    assign stall     = vld_f & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_f;
    assign sum       = sum_raw & {WIDTH{vld_f}};
    assign cout      = vld_f & g_f[WIDTH-1];
    assign ovf       = vld_f & (side_f.am == side_f.bm) & (sum_raw[WIDTH-1] != side_f.am);
    assign out_tag   = side_f.tag & {TAG_W{vld_f}};

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder: three configurations
// (32/PIPE_EVERY=1, 8/PIPE_EVERY=3, 64/PIPE_EVERY=2) checked against an
// arithmetic reference model.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(logic [63:0] s, logic c, logic o, logic [3:0] t);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.tag = t;
        return e;
    endfunction

    // Reference: unsigned sum for result/carry, signed range test for overflow
    function automatic exp_t model(int w, logic [63:0] ai, logic [63:0] bi,
                                   logic ci, logic sb, logic [3:0] t);
        exp_t e;
        logic [64:0] m;
        logic [63:0] av, bv;
        logic [65:0] ua;
        logic signed [66:0] sa, sbv, r, hi, lo;
        m  = (65'd1 << w) - 65'd1;
        av = ai & m[63:0];
        bv = bi & m[63:0];
        sa  = $signed({3'b000, av});
        sbv = $signed({3'b000, bv});
        if (av[w-1]) sa  = sa  - (67'sd1 <<< w);
        if (bv[w-1]) sbv = sbv - (67'sd1 <<< w);
        if (sb) begin
            ua     = {2'b00, av} - {2'b00, bv};
            e.cout = (av >= bv);
            r      = sa - sbv;
        end else begin
            ua     = {2'b00, av} + {2'b00, bv} + {65'd0, ci};
            e.cout = ua[w];
            r      = sa + sbv + $signed({66'd0, ci});
        end
        hi    = (67'sd1 <<< (w - 1)) - 67'sd1;
        lo    = -(67'sd1 <<< (w - 1));
        e.sum = ua[63:0] & m[63:0];
        e.ovf = (r > hi) || (r < lo);
        e.tag = t;
        return e;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- DUT instances ----------------
    logic        iv32, irdy32, ov32, ordy32, cin32, sub32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;
    logic [3:0]  tag32, otag32;

    logic        iv8, irdy8, ov8, ordy8, cin8, sub8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic [3:0]  tag8, otag8;

    logic        iv64, irdy64, ov64, ordy64, cin64, sub64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;
    logic [3:0]  tag64, otag64;

    pipelined_prefix_adder #(.WIDTH(32), .PIPE_EVERY(1), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(irdy32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .in_tag(tag32), .out_valid(ov32), .out_ready(ordy32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .out_tag(otag32));

    pipelined_prefix_adder #(.WIDTH(8), .PIPE_EVERY(3), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(irdy8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .out_tag(otag8));

    pipelined_prefix_adder #(.WIDTH(64), .PIPE_EVERY(2), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(irdy64), .a(a64), .b(b64),
        .cin(cin64), .sub(sub64), .in_tag(tag64), .out_valid(ov64), .out_ready(ordy64),
        .sum(sum64), .cout(cout64), .ovf(ovf64), .out_tag(otag64));

    exp_t q32[$];
    exp_t q8[$];
    exp_t q64[$];
    int   n_out32 = 0;
    int   n_stall32 = 0;

    // ---------------- monitors ----------------
    logic        stall_prev = 1'b0;
    logic [37:0] held = '0;

    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) check_eq("hold32", {sum32, cout32, ovf32, otag32}, held);
            if (ov32 && !ordy32) begin
                check_eq("in_ready_stall32", irdy32, 1'b0);
                n_stall32 <= n_stall32 + 1;
            end
            if (!ov32) begin
                check_eq("gate32", {sum32, cout32, ovf32, otag32}, 38'd0);
            end else if (ordy32) begin
                if (q32.size() == 0) begin
                    check_eq("extra32", ov32, 1'b0);
                end else begin
                    e = q32.pop_front();
                    check_eq("sum32", sum32, e.sum[31:0]);
                    check_eq("cout32", cout32, e.cout);
                    check_eq("ovf32", ovf32, e.ovf);
                    check_eq("tag32", otag32, e.tag);
                    n_out32 <= n_out32 + 1;
                end
            end
            stall_prev <= ov32 && !ordy32;
            held       <= {sum32, cout32, ovf32, otag32};
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst) begin
            if (!ov8) check_eq("gate8", {sum8, cout8, ovf8, otag8}, 14'd0);
            else if (q8.size() == 0) check_eq("extra8", ov8, 1'b0);
            else begin
                e = q8.pop_front();
                check_eq("sum8", sum8, e.sum[7:0]);
                check_eq("cout8", cout8, e.cout);
                check_eq("ovf8", ovf8, e.ovf);
                check_eq("tag8", otag8, e.tag);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst) begin
            if (!ov64) check_eq("gate64", {sum64, cout64, ovf64, otag64}, 70'd0);
            else if (q64.size() == 0) check_eq("extra64", ov64, 1'b0);
            else begin
                e = q64.pop_front();
                check_eq("sum64", sum64, e.sum);
                check_eq("cout64", cout64, e.cout);
                check_eq("ovf64", ovf64, e.ovf);
                check_eq("tag64", otag64, e.tag);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, input logic [3:0] t, input exp_t e);
        int w;
        a32 = av; b32 = bv; cin32 = ci; sub32 = sb; tag32 = t; iv32 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!irdy32 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check_eq("send32_timeout", irdy32, 1'b1);
        else q32.push_back(e);
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic sb, input logic [3:0] t, input exp_t e);
        a8 = av; b8 = bv; cin8 = ci; sub8 = sb; tag8 = t; iv8 = 1'b1;
        @(negedge clk);
        check_eq("irdy8", irdy8, 1'b1);
        q8.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                          input logic sb, input logic [3:0] t, input exp_t e);
        a64 = av; b64 = bv; cin64 = ci; sub64 = sb; tag64 = t; iv64 = 1'b1;
        @(negedge clk);
        check_eq("irdy64", irdy64, 1'b1);
        q64.push_back(e);
        @(posedge clk); #1;
        iv64 = 1'b0;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 100 && (q32.size() + q8.size() + q64.size()) != 0; i++) @(posedge clk);
        #1;
        check_eq("drain32", q32.size(), 0);
        check_eq("drain8", q8.size(), 0);
        check_eq("drain64", q64.size(), 0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, t0, o0;
        logic [31:0] ra, rb;
        logic rc, rs;
        rst = 1'b1;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; tag32 = 0; ordy32 = 1;
        iv8  = 0; a8  = 0; b8  = 0; cin8  = 0; sub8  = 0; tag8  = 0; ordy8  = 1;
        iv64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; tag64 = 0; ordy64 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ov32", ov32, 1'b0);
        check_eq("rst_out32", {sum32, cout32, ovf32, otag32}, 38'd0);
        check_eq("rst_ov8", ov8, 1'b0);
        check_eq("rst_ov64", ov64, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_irdy32", irdy32, 1'b1);
        @(posedge clk); #1;

        // 1: wrap-around add with latency measurement
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3, mk(64'h0, 1'b1, 1'b0, 4'd3));
        lat = 1;
        while (!ov32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("lat32", lat, 6);
        drain_all();

        // 2/3: subtract and carry-in directed cases
        send32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'd1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 4'd1));
        send32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'd2, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 4'd2));
        send32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'd4, mk(64'h8000_0000, 1'b0, 1'b1, 4'd4));
        send32(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 4'd5, mk(64'h0, 1'b1, 1'b0, 4'd5));
        drain_all();

        // 3: 1000-op back-to-back random stream
        t0 = cyc; o0 = n_out32;
        for (int i = 0; i < 1000; i++) begin
            ra = pick32(); rb = pick32(); rc = 1'($urandom); rs = 1'($urandom);
            send32(ra, rb, rc, rs, 4'(i), model(32, {32'd0, ra}, {32'd0, rb}, rc, rs, 4'(i)));
        end
        check_eq("thru32_cycles", cyc - t0, 1000);
        drain_all();
        check_eq("stream32_count", n_out32 - o0, 1000);

        // 4: backpressure while streaming tags 0..9
        o0 = n_out32; t0 = n_stall32;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = $urandom; rb = $urandom;
                    send32(ra, rb, 1'b0, 1'b0, 4'(i), model(32, {32'd0, ra}, {32'd0, rb}, 1'b0, 1'b0, 4'(i)));
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1 ordy32 = 1'b0;
                repeat (5) @(posedge clk);
                #1 ordy32 = 1'b1;
            end
        join
        drain_all();
        check_eq("bp_count32", n_out32 - o0, 10);
        check_eq("bp_stall_cycles32", n_stall32 - t0, 5);

        // 5: reset with four operations in flight
        o0 = n_out32;
        for (int i = 0; i < 4; i++)
            send32(32'(i + 1), 32'h10, 1'b0, 1'b0, 4'(8 + i), mk(64'(i + 17), 1'b0, 1'b0, 4'(8 + i)));
        rst = 1'b1;
        q32.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("rst_mid_irdy32", irdy32, 1'b1);
            check_eq("rst_mid_ov32", ov32, 1'b0);
            check_eq("rst_mid_sum32", sum32, 32'd0);
        end
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_mid_discard32", n_out32 - o0, 0);
        send32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'd6, mk(64'h100, 1'b0, 1'b0, 4'd6));
        drain_all();

        // 6: other parameterisations
        send8(8'hC8, 8'h64, 1'b0, 1'b0, 4'd5, mk(64'h2C, 1'b1, 1'b0, 4'd5));
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("lat8", lat, 2);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 4'd6, mk(64'h80, 1'b0, 1'b1, 4'd6));
        send8(8'h00, 8'h01, 1'b1, 1'b1, 4'd7, mk(64'hFF, 1'b0, 1'b0, 4'd7));
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            send8(ra[7:0], rb[7:0], rc, rs, 4'(i), model(8, {56'd0, ra[7:0]}, {56'd0, rb[7:0]}, rc, rs, 4'(i)));
        end
        drain_all();

        send64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'd9, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'd9));
        lat = 1;
        while (!ov64 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("lat64", lat, 4);
        for (int i = 0; i < 200; i++) begin
            logic [63:0] xa, xb;
            xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
            if (i % 7 == 0) xb = ~xa;
            rc = 1'($urandom); rs = 1'($urandom);
            send64(xa, xb, rc, rs, 4'(i), model(64, xa, xb, rc, rs, 4'(i)));
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
